clear_phase_sequencer: RTL and testbench

- Single-clock master FSM that walks one side of a CDC pair through the clear sequence: IDLE -> ISOLATE -> CLEAR -> POST_CLEAR -> IDLE.
- Uses the shared clear_seq_phase_e encoding from cdc_reset_ctrlr_pkg.
- Announces every phase on a valid/ready channel toward the CDC transport (peer acknowledgment), drives local isolate/clear controls, and waits for local quiescence before clearing.
- Sits between the soft-clear source and the CDC datapath halves.

---
 rtl/cdc_reset_ctrlr_pkg.sv | 11 +
 rtl/clear_phase_sequencer.sv | 129 ++++++++++++
 tb/tb_clear_phase_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cdc_reset_ctrlr_pkg.sv
// rtl/cdc_reset_ctrlr_pkg.sv - shared clear-sequence phase encoding for the CDC reset controller
package cdc_reset_ctrlr_pkg;

  typedef enum logic [1:0] {
    CLR_PHASE_IDLE       = 2'd0,
    CLR_PHASE_ISOLATE    = 2'd1,
    CLR_PHASE_CLEAR      = 2'd2,
    CLR_PHASE_POST_CLEAR = 2'd3
  } clear_seq_phase_e;

endpackage

// File: rtl/clear_phase_sequencer.sv
// rtl/clear_phase_sequencer.sv - master FSM walking one CDC half through isolate/clear/post-clear
module clear_phase_sequencer
  import cdc_reset_ctrlr_pkg::*;
#(
  parameter int ClearCycles = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_req_i,
  input  logic       isolated_i,
  output logic       isolate_o,
  output logic       clear_o,
  output logic [1:0] phase_o,
  output logic       phase_valid_o,
  input  logic       phase_ready_i,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CntW = $clog2(ClearCycles + 1);

  if (ClearCycles < 1) begin : g_bad_clear_cycles
    $error("ClearCycles must be >= 1");
  end

  clear_seq_phase_e r_phase, w_phase_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_acked, w_acked_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_pending, w_pending_nxt;
  logic            r_isolate, w_isolate_nxt;
  logic            r_clear, w_clear_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            w_hs;
  logic            w_ack;
  logic            w_enter;

  assign w_hs  = r_valid & phase_ready_i;
  assign w_ack = r_acked | w_hs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_phase   <= CLR_PHASE_IDLE;
      r_valid   <= 1'b0;
      r_acked   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pending <= 1'b0;
      r_isolate <= 1'b0;
      r_clear   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_valid   <= w_valid_nxt;
      r_acked   <= w_acked_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pending <= w_pending_nxt;
      r_isolate <= w_isolate_nxt;
      r_clear   <= w_clear_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_phase_nxt   = r_phase;
    w_valid_nxt   = r_valid & ~w_hs;
    w_acked_nxt   = r_acked | w_hs;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    // Requests arriving mid-sequence collapse into a single follow-up run.
    w_pending_nxt = r_pending | (clear_req_i & r_busy);
    w_cnt_nxt     = (r_cnt == '0) ? r_cnt : r_cnt - CntW'(1);
    w_enter       = 1'b0;

    case (r_phase)
      CLR_PHASE_IDLE: begin
        if (r_busy) begin
          if (w_hs) begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
          end
        end else if (clear_req_i || r_pending) begin
          w_phase_nxt   = CLR_PHASE_ISOLATE;
          w_enter       = 1'b1;
          w_busy_nxt    = 1'b1;
          w_pending_nxt = 1'b0;
        end
      end
      CLR_PHASE_ISOLATE: begin
        if (w_ack && isolated_i) begin
          w_phase_nxt = CLR_PHASE_CLEAR;
          w_enter     = 1'b1;
          w_cnt_nxt   = CntW'(ClearCycles - 1);
        end
      end
      CLR_PHASE_CLEAR: begin
        if ((r_cnt == '0) && w_ack) begin
          w_phase_nxt = CLR_PHASE_POST_CLEAR;
          w_enter     = 1'b1;
        end
      end
      CLR_PHASE_POST_CLEAR: begin
        if (w_ack) begin
          w_phase_nxt = CLR_PHASE_IDLE;
          w_enter     = 1'b1;
        end
      end
      default: ;
    endcase

    if (w_enter) begin
      w_valid_nxt = 1'b1;
      w_acked_nxt = 1'b0;
    end

    w_isolate_nxt = (w_phase_nxt != CLR_PHASE_IDLE);
    w_clear_nxt   = (w_phase_nxt == CLR_PHASE_CLEAR);
  end

  assign phase_o       = r_phase;
  assign phase_valid_o = r_valid;
  assign isolate_o     = r_isolate;
  assign clear_o       = r_clear;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

endmodule

// File: tb/tb_clear_phase_sequencer.sv
// tb/tb_clear_phase_sequencer.sv - directed self-checking bench for clear_phase_sequencer
module tb_clear_phase_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       clear_req_i;
  logic       isolated_i;
  logic       isolate_o;
  logic       clear_o;
  logic [1:0] phase_o;
  logic       phase_valid_o;
  logic       phase_ready_i;
  logic       busy_o;
  logic       done_o;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_ISO  = 2'd1;
  localparam logic [1:0] P_CLR  = 2'd2;
  localparam logic [1:0] P_POST = 2'd3;

  clear_phase_sequencer #(.ClearCycles(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_req_i   (clear_req_i),
    .isolated_i    (isolated_i),
    .isolate_o     (isolate_o),
    .clear_o       (clear_o),
    .phase_o       (phase_o),
    .phase_valid_o (phase_valid_o),
    .phase_ready_i (phase_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  // status vector: {phase[1:0], valid, isolate, clear, busy, done}
  function automatic logic [6:0] status();
    return {phase_o, phase_valid_o, isolate_o, clear_o, busy_o, done_o};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  logic [6:0] exp_nom [1:9];

  initial begin
    exp_nom[1] = {P_ISO,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_nom[2] = {P_CLR,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_nom[3] = {P_CLR,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_nom[4] = {P_CLR,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_nom[5] = {P_CLR,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_nom[6] = {P_POST, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_nom[7] = {P_IDLE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_nom[8] = {P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_nom[9] = {P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_ni        = 1'b0;
    clear_req_i   = 1'b0;
    isolated_i    = 1'b0;
    phase_ready_i = 1'b0;
    repeat (3) step();
    rst_ni = 1'b1;

    // reset and quiescent idle
    for (int c = 0; c < 10; c++) begin
      step();
      check_val("idle_quiet", status(), 7'b0);
    end

    // nominal sequence
    phase_ready_i = 1'b1;
    isolated_i    = 1'b1;
    clear_req_i   = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      clear_req_i = 1'b0;
      check_val($sformatf("nominal_c%0d", c), status(), exp_nom[c]);
    end

    // backpressure in ISOLATE, then stall in CLEAR after counter expiry
    phase_ready_i = 1'b0;
    clear_req_i   = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      clear_req_i = 1'b0;
      check_val($sformatf("bp_iso_c%0d", c), status(), {P_ISO, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    phase_ready_i = 1'b1;
    step();
    check_val("bp_clr_entry", status(), {P_CLR, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    phase_ready_i = 1'b0;
    for (int c = 8; c <= 13; c++) begin
      step();
      check_val($sformatf("bp_clr_c%0d", c), status(), {P_CLR, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    end
    phase_ready_i = 1'b1;
    step();
    check_val("bp_post", status(), {P_POST, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    step();
    check_val("bp_idle_ann", status(), {P_IDLE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    step();
    check_val("bp_done", status(), {P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    // isolated_i low after ISOLATE ack
    isolated_i  = 1'b0;
    clear_req_i = 1'b1;
    step();
    clear_req_i = 1'b0;
    check_val("iso_wait_c1", status(), {P_ISO, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    for (int c = 2; c <= 8; c++) begin
      step();
      if (c == 8) isolated_i = 1'b1;
      check_val($sformatf("iso_wait_c%0d", c), status(), {P_ISO, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    step();
    isolated_i = 1'b0;
    check_val("iso_wait_clr", status(), {P_CLR, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    repeat (4) step();
    check_val("iso_drop_post", status(), {P_POST, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    repeat (2) step();
    check_val("iso_drop_done", status(), {P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    // pending requests collapse into one follow-up sequence
    isolated_i  = 1'b1;
    clear_req_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      clear_req_i = (c == 2 || c == 3 || c == 5 || c == 7);
    end
    clear_req_i = 1'b0;
    check_val("pend_done", status(), {P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    step();
    check_val("pend_restart", status(), {P_ISO, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    repeat (7) step();
    check_val("pend_done2", status(), {P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int c = 0; c < 4; c++) begin
      step();
      check_val("pend_no_third", status(), 7'b0);
    end

    // asynchronous reset in CLEAR with a pending request
    clear_req_i = 1'b1;
    step();
    step();
    step();
    clear_req_i = 1'b1;
    step();
    clear_req_i = 1'b0;
    check_val("rst_pre_clr", status(), {P_CLR, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    #2 rst_ni = 1'b0;
    #1;
    check_val("rst_async", status(), 7'b0);
    repeat (2) step();
    rst_ni = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check_val("rst_no_restart", status(), 7'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
